bcd2bin_seq: RTL



---
 rtl/bcd2bin_seq_pkg.sv | 14 +
 rtl/bcd2bin_seq_digit_corr.sv | 12 +
 rtl/bcd2bin_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// rtl/bcd2bin_seq_pkg.sv - shared state encodings and BCD correction constants
package bcd2bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_CORR   = 4'd3;
    localparam logic [3:0] BCD_THRESH = 4'd8;
    localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd2bin_seq_digit_corr.sv
// rtl/bcd2bin_seq_digit_corr.sv - reverse double-dabble digit correction (d>=8 ? d-3 : d)
module bcd_digit_corr
    import bcd2bin_seq_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // d >= 8 guarantees the 4-bit subtraction never borrows
    assign d_o = (d_i >= BCD_THRESH) ? (d_i - BCD_CORR) : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter (shift right, subtract-3)
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int BIN_W = 7
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic [BIN_W-1:0]    bin_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SW = 4*NDIG + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    s_q, s_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             err_q, err_d;

    logic [SW-1:0]    s_shift;
    logic [SW-1:0]    s_corr;
    logic             bcd_bad;

    assign s_shift = s_q >> 1;
    assign s_corr[BIN_W-1:0] = s_shift[BIN_W-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .d_i (s_shift[BIN_W + 4*g +: 4]),
            .d_o (s_corr[BIN_W + 4*g +: 4])
        );
    end

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX) bcd_bad = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d   = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d = '0;
                    if (bcd_bad) begin
                        bin_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                s_d   = s_corr;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bin_d   = s_corr[BIN_W-1:0];
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bin_out = bin_q;
    assign err     = err_q;
    assign busy    = (state_q == ST_CONV);
    assign done    = (state_q == ST_DONE);

endmodule
